// File: rtl/app_axi_arbiter_if.sv
// app_axi_arbiter_if: requester-side and AXI-master-side signals of the round-robin arbiter.
interface app_axi_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_rd_wr;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          req_err;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          m_valid;
    logic                          m_rd_wr;
    logic [ADDR_WIDTH-1:0]         m_addr;
    logic [DATA_WIDTH-1:0]         m_data;
    logic                          m_ack;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          busy;
    logic [IW-1:0]                 grant_idx;
    modport master (
        input  req_valid, req_rd_wr, req_addr, req_data, m_ack, m_rdata,
        output req_ack, req_err, rsp_data, m_valid, m_rd_wr, m_addr, m_data, busy, grant_idx
    );
    modport slave (
        output req_valid, req_rd_wr, req_addr, req_data, m_ack, m_rdata,
        input  req_ack, req_err, rsp_data, m_valid, m_rd_wr, m_addr, m_data, busy, grant_idx
    );
endinterface

// File: rtl/app_axi_arbiter.sv
// app_axi_arbiter: round-robin arbiter funnelling NUM_REQ requesters onto one AXI master port.
// Define APP_ARB_TIMEOUT_EN to complete a stalled WAIT with req_err after TIMEOUT_CYCLES.
module app_axi_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              aclk,
    input logic              areset,
    app_axi_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("app_axi_arbiter: parameter out of range");
    end

    logic [1:0]            r_state;
    logic [IW-1:0]         r_grant;
    logic [IW-1:0]         r_last;
    logic                  r_m_valid;
    logic                  r_m_rd_wr;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic [NUM_REQ-1:0]    r_req_ack;
    logic                  r_req_err;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  w_hi;
    logic [IW-1:0]         w_hi_idx;
    logic [IW-1:0]         w_lo_idx;
    logic [IW-1:0]         w_win;
    logic                  w_to;

    // Prefer the lowest requester above last_grant, otherwise wrap to the lowest overall.
    always_comb begin
        w_hi     = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req_valid[j]) begin
                w_lo_idx = IW'(j);
                if (IW'(j) > r_last) begin
                    w_hi     = 1'b1;
                    w_hi_idx = IW'(j);
                end
            end
        end
        w_win = w_hi ? w_hi_idx : w_lo_idx;
    end

`ifdef APP_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_cnt <= '0;
        else
            r_cnt <= (r_state == S_WAIT) ? r_cnt + 16'd1 : 16'd0;
    end
    assign w_to = (r_state == S_WAIT) && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= IW'(NUM_REQ - 1);
            r_m_valid  <= 1'b0;
            r_m_rd_wr  <= 1'b0;
            r_m_addr   <= '0;
            r_m_data   <= '0;
            r_req_ack  <= '0;
            r_req_err  <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            r_m_valid <= 1'b0;
            r_req_ack <= '0;
            r_req_err <= 1'b0;
            case (r_state)
                S_IDLE: if (|bus.req_valid) begin
                    r_state   <= S_ISSUE;
                    r_m_valid <= 1'b1;
                    r_grant   <= w_win;
                    r_m_rd_wr <= bus.req_rd_wr[w_win];
                    r_m_addr  <= bus.req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                    r_m_data  <= bus.req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: if (bus.m_ack || w_to) begin
                    r_state   <= S_IDLE;
                    r_req_ack <= NUM_REQ'(1) << r_grant;
                    r_req_err <= !bus.m_ack;
                    r_last    <= r_grant;
                    if (bus.m_ack && !r_m_rd_wr)
                        r_rsp_data <= bus.m_rdata;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ack   = r_req_ack;
    assign bus.req_err   = r_req_err;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_rd_wr   = r_m_rd_wr;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_data    = r_m_data;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.grant_idx = r_grant;
endmodule

// File: tb/tb_app_axi_arbiter.sv
// tb_app_axi_arbiter: vector table plus scoreboard of expected issues for app_axi_arbiter.
module tb_app_axi_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic [1:0]  g;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  rw;
        logic [1:0]  g;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          dly;
        bit          drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rsp = '0;
    exp_t sb[$];
    vec_t vt[6];

    app_axi_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    app_axi_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .aclk(clk), .areset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] rw, input logic [1:0] g,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_rd_wr = rw;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = (i == int'(g)) ? a : 32'hF000_0000 | i;
            bus.req_data[i*DW +: DW] = (i == int'(g)) ? d : 32'h0BAD_0000 | i;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_rd_wr", bus.m_rd_wr, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_req_ack", bus.req_ack, 0);
        chk("rst_req_err", bus.req_err, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant_idx", bus.grant_idx, 0);
        exp_rsp = '0;
        repeat (2) @(negedge clk);
        chk("rst_hold_req_ack", bus.req_ack, 0);
        rst = 1'b0;
    endtask

    task automatic issue_chk(output bit ok, output exp_t e);
        int c;
        ok = 1'b0;
        e = '{default: '0};
        @(negedge clk);
        for (c = 0; c < 12 && !bus.m_valid; c++) @(negedge clk);
        chk("m_valid_seen", bus.m_valid, 1);
        if (!bus.m_valid) return;
        chk("issue_latency", c, 0);
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        ok = 1'b1;
        chk("grant_idx", bus.grant_idx, e.g);
        chk("m_addr", bus.m_addr, e.addr);
        chk("m_data", bus.m_data, e.data);
        chk("m_rd_wr", bus.m_rd_wr, e.rw);
        chk("busy_issue", bus.busy, 1);
    endtask

    task automatic txn(input int dly, input logic [31:0] rd, input bit drop);
        bit ok;
        exp_t e;
        issue_chk(ok, e);
        if (!ok) return;
        if (drop) bus.req_valid = '0;
        @(negedge clk);
        chk("m_valid_pulse", bus.m_valid, 0);
        chk("busy_wait", bus.busy, 1);
        chk("m_addr_stable", bus.m_addr, e.addr);
        repeat (dly) @(negedge clk);
        chk("no_early_ack", bus.req_ack, 0);
        bus.m_ack = 1'b1;
        bus.m_rdata = rd;
        @(negedge clk);
        bus.m_ack = 1'b0;
        bus.m_rdata = '0;
        if (!e.rw) exp_rsp = rd;
        chk("req_ack", bus.req_ack, 4'b1 << e.g);
        chk("req_err", bus.req_err, 0);
        chk("rsp_data", bus.rsp_data, exp_rsp);
    endtask

    initial begin
        bit ok;
        exp_t e;
        int k;
        vt[0] = '{4'b0001, 4'b0001, 2'd0, 32'h100, 32'hDEADBEEF, 32'h0, 3, 1'b0};
        vt[1] = '{4'b0100, 4'b0000, 2'd2, 32'h40, 32'h0, 32'h12345678, 1, 1'b0};
        vt[2] = '{4'b0010, 4'b0010, 2'd1, 32'h200, 32'hCAFEF00D, 32'hBAD0BAD0, 0, 1'b0};
        vt[3] = '{4'b1100, 4'b0000, 2'd2, 32'h3C0, 32'h0, 32'hA5A5A5A5, 2, 1'b0};
        vt[4] = '{4'b1001, 4'b1001, 2'd3, 32'h7FC, 32'h01020304, 32'h0, 0, 1'b1};
        vt[5] = '{4'b0011, 4'b0000, 2'd0, 32'h8, 32'h0, 32'h0F0F0F0F, 5, 1'b1};
        drive(4'b0, 4'b0, 2'd0, 32'h0, 32'h0);
        bus.m_ack = 1'b0;
        bus.m_rdata = '0;
        @(negedge clk);
        apply_reset();

        foreach (vt[i]) begin
            drive(vt[i].valid, vt[i].rw, vt[i].g, vt[i].addr, vt[i].data);
            sb.push_back('{vt[i].g, vt[i].rw[vt[i].g], vt[i].addr, vt[i].data});
            txn(vt[i].dly, vt[i].rdata, vt[i].drop);
            bus.req_valid = '0;
            @(negedge clk);
            chk("ack_one_cycle", bus.req_ack, 0);
            chk("busy_idle", bus.busy, 0);
        end

        bus.m_ack = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.m_ack = 1'b0;
        @(negedge clk);
        chk("spurious_req_ack", bus.req_ack, 0);
        chk("spurious_busy", bus.busy, 0);
        chk("spurious_rsp", bus.rsp_data, exp_rsp);

        drive(4'b0100, 4'b0000, 2'd2, 32'h44, 32'h0);
        sb.push_back('{2'd2, 1'b0, 32'h44, 32'h0});
        issue_chk(ok, e);
        @(negedge clk);
        chk("abort_busy", bus.busy, 1);
        bus.req_valid = 4'b1111;
        bus.req_rd_wr = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 4);
            bus.req_data[i*DW +: DW] = 32'hA000 + 32'(i);
        end
        for (int n = 0; n < 5; n++)
            sb.push_back('{2'(n % 4), 1'b1, 32'h1000 + 32'((n % 4) * 4), 32'hA000 + 32'(n % 4)});
        apply_reset();
        for (int n = 0; n < 5; n++) txn(0, 32'h5555_5555, 1'b0);
        bus.req_valid = '0;
        @(negedge clk);

        drive(4'b0010, 4'b0010, 2'd1, 32'h900, 32'h77);
        sb.push_back('{2'd1, 1'b1, 32'h900, 32'h77});
        issue_chk(ok, e);
        bus.req_valid = '0;
`ifdef APP_ARB_TIMEOUT_EN
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.req_ack != 0) break;
        end
        chk("timeout_cycles", k, 9);
        chk("timeout_req_ack", bus.req_ack, 4'b0010);
        chk("timeout_req_err", bus.req_err, 1);
        chk("timeout_rsp", bus.rsp_data, exp_rsp);
        @(negedge clk);
        chk("timeout_err_pulse", bus.req_err, 0);
        chk("timeout_idle", bus.busy, 0);
`else
        k = 0;
        repeat (30) @(negedge clk);
        chk("no_timeout_busy", bus.busy, 1);
        chk("no_timeout_ack", bus.req_ack, 0);
        apply_reset();
`endif
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
